// File: rtl/sa_skew_feeder_pkg.sv
// Shared state type, flush-length helper and lane slicing helpers for the skewed operand feeder.
package sa_feed_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } feed_state_e;

  localparam int BUBBLE_CNT_W = 16;

  // Cycles for the last skewed operand to cross the array and land in the far PE register.
  function automatic int flush_cyc(input int n, input int pe_lat);
    return 2 * (n - 1) + pe_lat;
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/sa_skew_feeder_if.sv
// Operand/control bundle between an upstream producer (master) and the skew feeder (slave).
// bubble_cnt exists only when SA_FEEDER_BUBBLE_CNT_EN is defined.
interface sa_skew_feeder_if #(
  parameter int N     = 8,
  parameter int WIDTH = 8,
  parameter int KMAX  = 255
);
  import sa_feed_pkg::*;

  localparam int CW = $clog2(KMAX + 1);

  logic                 start;
  logic [CW-1:0]        k_len;
  logic                 in_valid;
  logic                 in_ready;
  logic [N*WIDTH-1:0]   a_vec;
  logic [N*WIDTH-1:0]   b_vec;
  logic [N*WIDTH-1:0]   AA;
  logic [N*WIDTH-1:0]   BB;
  logic                 arr_clr;
  logic                 busy;
  logic                 done;
`ifdef SA_FEEDER_BUBBLE_CNT_EN
  logic [BUBBLE_CNT_W-1:0] bubble_cnt;

  modport master (output start, k_len, in_valid, a_vec, b_vec,
                  input  in_ready, AA, BB, arr_clr, busy, done, bubble_cnt);
  modport slave  (input  start, k_len, in_valid, a_vec, b_vec,
                  output in_ready, AA, BB, arr_clr, busy, done, bubble_cnt);
`else
  modport master (output start, k_len, in_valid, a_vec, b_vec,
                  input  in_ready, AA, BB, arr_clr, busy, done);
  modport slave  (input  start, k_len, in_valid, a_vec, b_vec,
                  output in_ready, AA, BB, arr_clr, busy, done);
`endif

endinterface

// File: rtl/sa_skew_feeder_line.sv
// Zero-fill shift line of DEPTH registers: din appears DEPTH cycles later, vld_i=0 shifts in zero.
// No backpressure: it shifts every cycle.
module sa_skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= vld_i ? din_i : '0;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// Skewed A/B feeder for sa_2D: lane k shows its accepted operand k+1 cycles later; done = last accept + FLUSH_CYC + 1.
// in_ready only in FEED; invalid FEED cycles become zero slots so the array never stalls. Option: SA_FEEDER_BUBBLE_CNT_EN.
module sa_skew_feeder
  import sa_feed_pkg::*;
#(
  parameter int N      = 8,
  parameter int WIDTH  = 8,
  parameter int KMAX   = 255,
  parameter int PE_LAT = 1
) (
  input  logic CLK,
  input  logic RST,
  sa_skew_feeder_if.slave bus
);

  localparam int CW        = $clog2(KMAX + 1);
  localparam int FLUSH_CYC = flush_cyc(N, PE_LAT);
  localparam int FW        = $clog2(FLUSH_CYC + 1);
  localparam logic [FW-1:0] FL_LAST = FW'(FLUSH_CYC - 1);

  feed_state_e   state_q;
  logic [CW-1:0] k_len_q;
  logic [CW-1:0] acc_cnt_q;
  logic [CW-1:0] acc_cnt_d;
  logic [FW-1:0] fl_cnt_q;
  logic          in_ready_q;
  logic          arr_clr_q;
  logic          busy_q;
  logic          done_q;
  logic          accept;

  assign accept    = bus.in_valid & in_ready_q;
  assign acc_cnt_d = acc_cnt_q + CW'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      k_len_q    <= '0;
      acc_cnt_q  <= '0;
      fl_cnt_q   <= '0;
      in_ready_q <= 1'b0;
      arr_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      arr_clr_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            k_len_q   <= bus.k_len;
            acc_cnt_q <= '0;
            fl_cnt_q  <= '0;
            arr_clr_q <= 1'b1;
            busy_q    <= 1'b1;
            // An empty tile still clears the array and waits out the flush.
            if (bus.k_len != '0) begin
              state_q    <= FEED;
              in_ready_q <= 1'b1;
            end else begin
              state_q    <= FLUSH;
            end
          end
        end
        FEED: begin
          if (accept) begin
            acc_cnt_q <= acc_cnt_d;
            if (acc_cnt_d == k_len_q) begin
              state_q    <= FLUSH;
              in_ready_q <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (fl_cnt_q == FL_LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            fl_cnt_q <= fl_cnt_q + FW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [N*WIDTH-1:0] aa_w;
  logic [N*WIDTH-1:0] bb_w;

  for (genvar k = 0; k < N; k++) begin : g_lane
    localparam int LSB = lane_lsb(k, WIDTH);

    sa_skew_line #(.DEPTH(k + 1), .WIDTH(WIDTH)) u_a (
      .clk   (CLK),
      .rst   (RST),
      .vld_i (accept),
      .din_i (bus.a_vec[LSB +: WIDTH]),
      .dout_o(aa_w[LSB +: WIDTH])
    );

    sa_skew_line #(.DEPTH(k + 1), .WIDTH(WIDTH)) u_b (
      .clk   (CLK),
      .rst   (RST),
      .vld_i (accept),
      .din_i (bus.b_vec[LSB +: WIDTH]),
      .dout_o(bb_w[LSB +: WIDTH])
    );
  end

  assign bus.AA       = aa_w;
  assign bus.BB       = bb_w;
  assign bus.in_ready = in_ready_q;
  assign bus.arr_clr  = arr_clr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

`ifdef SA_FEEDER_BUBBLE_CNT_EN
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_q;

  // Cleared on the edge that raises arr_clr, so it reads 0 throughout the clear cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bubble_cnt_q <= '0;
    end else if (state_q == IDLE && bus.start) begin
      bubble_cnt_q <= '0;
    end else if (state_q == FEED && !bus.in_valid && bubble_cnt_q != '1) begin
      bubble_cnt_q <= bubble_cnt_q + BUBBLE_CNT_W'(1);
    end
  end

  assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Scoreboard bench for sa_skew_feeder with N=4, WIDTH=8, PE_LAT=1 (flush of 7 cycles).
module tb_sa_skew_feeder;

  localparam int N      = 4;
  localparam int WIDTH  = 8;
  localparam int KMAX   = 255;
  localparam int PE_LAT = 1;
  localparam int CW     = $clog2(KMAX + 1);
  localparam int FC     = 7;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  sa_skew_feeder_if #(.N(N), .WIDTH(WIDTH), .KMAX(KMAX)) bus ();

  sa_skew_feeder #(.N(N), .WIDTH(WIDTH), .KMAX(KMAX), .PE_LAT(PE_LAT)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    int               cyc;
    int               lane;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } ev_t;

  ev_t sbq[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic next_cyc;
    @(posedge CLK);
    #1;
  endtask

  // An accept at cycle t must surface on lane k at cycle t+k+1.
  task automatic push_vec(input int t, input logic [N*WIDTH-1:0] a, input logic [N*WIDTH-1:0] b);
    for (int k = 0; k < N; k++) begin
      ev_t e;
      e.cyc  = t + k + 1;
      e.lane = k;
      e.a    = a[k*WIDTH +: WIDTH];
      e.b    = b[k*WIDTH +: WIDTH];
      sbq.push_back(e);
    end
  endtask

  task automatic pop_exp(input int c, output logic [N*WIDTH-1:0] ea, output logic [N*WIDTH-1:0] eb);
    ea = '0;
    eb = '0;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == c) begin
        ea[sbq[i].lane*WIDTH +: WIDTH] = sbq[i].a;
        eb[sbq[i].lane*WIDTH +: WIDTH] = sbq[i].b;
        sbq.delete(i);
      end
    end
  endtask

  // One tile from start to done; vmask bit f is in_valid in the f-th FEED cycle, glitch>=0 re-pulses start.
  task automatic run_tile(input string nm, input int klen, input logic [31:0] vmask,
                          input int glitch, input logic [N*WIDTH-1:0] a0);
    int acc = 0, f = 0, s, last = -1, bub = 0, c;
    bit in_feed = 1'b0;
    logic [N*WIDTH-1:0] a, b, ea, eb;
    s = cyc;
    bus.start    = 1'b1;
    bus.k_len    = CW'(klen);
    bus.in_valid = 1'b1;
    bus.a_vec    = $urandom;
    bus.b_vec    = $urandom;
    if (klen == 0) last = s;
    for (int i = 0; i < 400; i++) begin
      c = cyc;
      if (i > 0) begin
        bus.start = (glitch >= 0 && i == glitch + 1);
        bus.k_len = CW'(klen + 3);
        in_feed   = (klen > 0) && (acc < klen);
        a = $urandom;
        b = $urandom;
        if (in_feed && acc == 0 && a0 != '0) a = a0;
        bus.a_vec    = a;
        bus.b_vec    = b;
        bus.in_valid = in_feed ? ((f < 32) ? vmask[f] : 1'b1) : 1'b1;
        if (in_feed) begin
          if (bus.in_valid) begin
            push_vec(c, a, b);
            acc++;
            if (acc == klen) last = c;
          end else begin
            bub++;
          end
          f++;
        end
      end
      @(negedge CLK);
      pop_exp(c, ea, eb);
      n_cmp += 6;
      if (bus.AA !== ea) begin n_bad++; $display("FAIL %s AA @%0d: got %h want %h", nm, c - s, bus.AA, ea); end
      if (bus.BB !== eb) begin n_bad++; $display("FAIL %s BB @%0d: got %h want %h", nm, c - s, bus.BB, eb); end
      if (bus.in_ready !== in_feed) begin n_bad++; $display("FAIL %s in_ready @%0d: got %b want %b", nm, c - s, bus.in_ready, in_feed); end
      if (bus.arr_clr !== (c == s + 1)) begin n_bad++; $display("FAIL %s arr_clr @%0d: got %b want %b", nm, c - s, bus.arr_clr, c == s + 1); end
      if (bus.busy !== (c > s && (last < 0 || c <= last + FC + 1))) begin
        n_bad++; $display("FAIL %s busy @%0d: got %b", nm, c - s, bus.busy);
      end
      if (bus.done !== (last >= 0 && c == last + FC + 1)) begin
        n_bad++; $display("FAIL %s done @%0d: got %b want %b", nm, c - s, bus.done, last >= 0 && c == last + FC + 1);
      end
`ifdef SA_FEEDER_BUBBLE_CNT_EN
      if (c == s + 1) begin
        n_cmp++;
        if (bus.bubble_cnt !== 16'd0) begin n_bad++; $display("FAIL %s bubble_cnt at clear: got %0d want 0", nm, bus.bubble_cnt); end
      end
      if (last >= 0 && c == last + FC + 1) begin
        n_cmp++;
        if (bus.bubble_cnt !== 16'(bub)) begin n_bad++; $display("FAIL %s bubble_cnt at done: got %0d want %0d", nm, bus.bubble_cnt, bub); end
      end
`endif
      if (last >= 0 && c == last + FC + 1) begin
        n_cmp++;
        if (sbq.size() != 0) begin n_bad++; $display("FAIL %s scoreboard leftover: got %0d want 0", nm, sbq.size()); end
        next_cyc();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        return;
      end
      next_cyc();
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s timeout: got no done want done", nm);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2 RST = 1'b1;
    #1;
    n_cmp += 6;
    if (bus.AA !== '0)       begin n_bad++; $display("FAIL reset AA: got %h want 0", bus.AA); end
    if (bus.BB !== '0)       begin n_bad++; $display("FAIL reset BB: got %h want 0", bus.BB); end
    if (bus.busy !== 1'b0)   begin n_bad++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    if (bus.done !== 1'b0)   begin n_bad++; $display("FAIL reset done: got %b want 0", bus.done); end
    if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset in_ready: got %b want 0", bus.in_ready); end
    if (bus.arr_clr !== 1'b0)  begin n_bad++; $display("FAIL reset arr_clr: got %b want 0", bus.arr_clr); end
    @(posedge CLK);
    next_cyc();
    RST = 1'b0;
  endtask

  task automatic test_single;
    run_tile("single", 1, 32'h1, -1, 32'h04030201);
  endtask

  task automatic test_bubble;
    run_tile("bubble", 3, 32'b1101, -1, '0);
  endtask

  task automatic test_k0;
    run_tile("k0", 0, 32'h0, -1, '0);
  endtask

  task automatic test_start_busy;
    run_tile("start_busy", 4, 32'hFFFF_FFFF, 1, '0);
  endtask

  task automatic test_back_to_back;
    run_tile("b2b_0", 2, 32'hFFFF_FFFF, -1, '0);
    run_tile("b2b_1", 5, $urandom, -1, '0);
  endtask

  task automatic test_reset_mid;
    logic [N*WIDTH-1:0] a2;
    bus.start = 1'b1; bus.k_len = CW'(5); bus.in_valid = 1'b0;
    next_cyc();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.a_vec = $urandom; bus.b_vec = $urandom;
    next_cyc();
    a2 = $urandom | 32'h0101_0101;
    bus.a_vec = a2;
    next_cyc();
    bus.in_valid = 1'b0;
    @(negedge CLK);
    n_cmp += 2;
    if (bus.AA[WIDTH-1:0] !== a2[WIDTH-1:0]) begin n_bad++; $display("FAIL rst_mid lane0 pre: got %h want %h", bus.AA[WIDTH-1:0], a2[WIDTH-1:0]); end
    if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid busy pre: got %b want 1", bus.busy); end
    #2 RST = 1'b1;
    #1;
    n_cmp += 4;
    if (bus.AA !== '0)       begin n_bad++; $display("FAIL rst_mid AA: got %h want 0", bus.AA); end
    if (bus.BB !== '0)       begin n_bad++; $display("FAIL rst_mid BB: got %h want 0", bus.BB); end
    if (bus.busy !== 1'b0)   begin n_bad++; $display("FAIL rst_mid busy: got %b want 0", bus.busy); end
    if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid in_ready: got %b want 0", bus.in_ready); end
    @(posedge CLK);
    next_cyc();
    RST = 1'b0;
    sbq.delete();
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      n_cmp += 2;
      if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_mid done after reset @%0d: got 1 want 0", i); end
      if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid busy after reset @%0d: got 1 want 0", i); end
      next_cyc();
    end
    run_tile("post_rst", 3, 32'b1011, -1, '0);
  endtask

`ifdef SA_FEEDER_BUBBLE_CNT_EN
  task automatic test_bubble_cnt;
    run_tile("bcnt", 2, 32'b10001, -1, '0);
    next_cyc();
    next_cyc();
    @(negedge CLK);
    n_cmp++;
    if (bus.bubble_cnt !== 16'd3) begin n_bad++; $display("FAIL bcnt hold: got %0d want 3", bus.bubble_cnt); end
    next_cyc();
    run_tile("bcnt_clr", 1, 32'h1, -1, '0);
  endtask
`endif

  initial begin
    bus.start    = 1'b0;
    bus.k_len    = '0;
    bus.in_valid = 1'b0;
    bus.a_vec    = '0;
    bus.b_vec    = '0;
    test_reset();
    test_single();
    test_bubble();
    test_k0();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
`ifdef SA_FEEDER_BUBBLE_CNT_EN
    test_bubble_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
